// File: rtl/audio_pkg.sv
// Shared audio definitions: sample width, saturation limits and the
// 32->16 narrowing function used by the store path and the codec serializer.
package audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam logic [SAMPLE_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [SAMPLE_W-1:0] SAT_MIN = 16'h8000;

  // Returns {clipped, sample}. A word fits when its top SAMPLE_W+1 bits are
  // all copies of the sign; otherwise it clamps toward its sign.
  function automatic logic [SAMPLE_W:0] sat_narrow(input logic [2*SAMPLE_W-1:0] word);
    logic [SAMPLE_W:0] res;
    logic [SAMPLE_W:0] upper;
    upper = word[2*SAMPLE_W-1:SAMPLE_W-1];
    if ((&upper) || !(|upper)) begin
      res = {1'b0, word[SAMPLE_W-1:0]};
    end else if (word[2*SAMPLE_W-1]) begin
      res = {1'b1, SAT_MIN};
    end else begin
      res = {1'b1, SAT_MAX};
    end
    return res;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with a registered output stage.
// count covers every stored entry, including the one shown on dout.
// dout/dout_valid lag a write into an empty FIFO by one cycle (no bypass);
// after a pop the next entry is loaded in the same edge so a full-rate
// stream is sustained. dout holds the last popped value when empty.
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    rptr_nxt;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] dout_q;
  logic             valid_q;
  logic             wr;
  logic             pop;

  assign full     = (count_q == CW'(DEPTH));
  assign wr       = push & ~full;
  assign pop      = valid_q & pop_ready;
  assign rptr_nxt = rptr + 1'b1;

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign count      = count_q;

  // Storage array; no reset needed, contents are qualified by count.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr] <= din;
    end
  end

  // Pointers, occupancy and the registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (wr) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr_nxt;
      end
      case ({wr, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (pop) begin
        // Another older entry is already stored: present it immediately.
        if (count_q > CW'(1)) begin
          dout_q  <= mem[rptr_nxt];
          valid_q <= 1'b1;
        end else begin
          valid_q <= 1'b0;
        end
      end else if (!valid_q && (count_q != '0)) begin
        dout_q  <= mem[rptr];
        valid_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sample_narrow16.sv
// Narrows 32-bit signed datapath words to saturated 16-bit audio samples,
// buffers them and hands them to the codec path. Also counts clip events.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both 1. A source holding valid must keep its data stable until the
// transfer; valid never depends on ready. in_ready depends only on FIFO
// occupancy (0 when full), never combinationally on out_ready.
module sample_narrow16
  import audio_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               clip_pulse,
  output logic [CNT_W-1:0]   clip_count,
  output logic [CW-1:0]      count
);

  logic [WIDTH-1:0] sat_sample;
  logic             sat_clip;
  logic             fifo_full;
  logic             push;
  logic             clip_pulse_q;
  logic [CNT_W-1:0] clip_count_q;

  // The standard 16-bit width uses the shared narrowing function; other
  // widths use the same rule written generically.
  if (WIDTH == SAMPLE_W) begin : g_pkg_sat
    assign {sat_clip, sat_sample} = sat_narrow(in_data);
  end else begin : g_gen_sat
    logic [WIDTH:0] upper;
    assign upper = in_data[2*WIDTH-1:WIDTH-1];
    // Clamp toward the sign when the upper bits are not a pure sign extension.
    always_comb begin
      sat_clip   = 1'b0;
      sat_sample = in_data[WIDTH-1:0];
      if (!((&upper) || !(|upper))) begin
        sat_clip   = 1'b1;
        sat_sample = in_data[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
      end
    end
  end

  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;

  sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .din        (sat_sample),
    .pop_ready  (out_ready),
    .dout       (out_data),
    .dout_valid (out_valid),
    .full       (fifo_full),
    .count      (count)
  );

  // Clip event pulse and saturating clip counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      clip_pulse_q <= 1'b0;
      clip_count_q <= '0;
    end else begin
      clip_pulse_q <= push & sat_clip;
      if (push && sat_clip && !(&clip_count_q)) begin
        clip_count_q <= clip_count_q + 1'b1;
      end
    end
  end

  assign clip_pulse = clip_pulse_q;
  assign clip_count = clip_count_q;

endmodule

// File: tb/tb_sample_narrow16.sv
// Bench for sample_narrow16: table-driven vectors, directed corner sequences
// and a per-cycle scoreboard sampling on the falling edge.
module tb_sample_narrow16;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CW    = 3;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               clip_pulse;
  logic [CNT_W-1:0]   clip_count;
  logic [CW-1:0]      count;

  sample_narrow16 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .clip_pulse (clip_pulse),
    .clip_count (clip_count),
    .count      (count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [31:0] din;
    logic [15:0] exp;
    logic        clip;
  } vec_t;

  vec_t        vecs [5];
  logic [15:0] exp_q [$];
  logic [15:0] cur_exp;
  logic        cur_clip;
  logic        clip_next;
  int          clip_model;
  int          n_pulses;
  int          n_cmp;
  int          n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference saturation computed by signed range comparison.
  function automatic logic [16:0] ref_sat(input logic [31:0] w);
    int signed v;
    v = $signed(w);
    if (v > 32767)       return {1'b1, 16'h7FFF};
    else if (v < -32768) return {1'b1, 16'h8000};
    else                 return {1'b0, w[15:0]};
  endfunction

  // Per-cycle monitor: compares flags/occupancy, pops expected samples, and
  // records accepted words.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      clip_next  = 1'b0;
      clip_model = 0;
    end else begin
      check("clip_pulse", {31'd0, clip_pulse}, {31'd0, clip_next});
      check("clip_count", {24'd0, clip_count}, clip_model);
      check("count", {29'd0, count}, exp_q.size());
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() != DEPTH});
      if (clip_pulse) n_pulses++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL out_unexpected: got %0h expected no output at %0t", out_data, $time);
        end else begin
          check("out_data", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        clip_next = cur_clip;
        if (cur_clip && clip_model < 255) clip_model++;
      end else begin
        clip_next = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic [15:0] e, input logic c, input logic chk2);
    bit acc;
    acc      = 1'b0;
    in_data  = w;
    cur_exp  = e;
    cur_clip = c;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc && chk2) check("t4_count_steady", {29'd0, count}, 32'd2);
      step();
    end
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 for word %0h", w);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_ref(input logic [31:0] w, input logic chk2);
    logic [16:0] r;
    r = ref_sat(w);
    send(w, r[15:0], r[16], chk2);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      done = (exp_q.size() == 0);
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d entries expected 0", exp_q.size());
    end
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int p0;
    bit seen;
    n_cmp = 0; n_fail = 0; n_pulses = 0;
    clip_next = 1'b0; clip_model = 0;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cur_exp = '0; cur_clip = 1'b0;

    vecs[0] = '{din: 32'h0000_1234, exp: 16'h1234, clip: 1'b0};
    vecs[1] = '{din: 32'hFFFF_8000, exp: 16'h8000, clip: 1'b0};
    vecs[2] = '{din: 32'h0001_0000, exp: 16'h7FFF, clip: 1'b1};
    vecs[3] = '{din: 32'h8000_0000, exp: 16'h8000, clip: 1'b1};
    vecs[4] = '{din: 32'hFFFF_7FFF, exp: 16'h8000, clip: 1'b1};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_clip_count", {24'd0, clip_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();

    // 1. Pass-through, 2. saturation (table-driven)
    out_ready = 1'b1;
    p0 = n_pulses;
    for (int i = 0; i < 2; i++) send(vecs[i].din, vecs[i].exp, vecs[i].clip, 1'b0);
    drain();
    check("t1_clip_count", {24'd0, clip_count}, 32'd0);
    for (int i = 2; i < 5; i++) send(vecs[i].din, vecs[i].exp, vecs[i].clip, 1'b0);
    drain();
    check("t2_clip_count", {24'd0, clip_count}, 32'd3);
    check("t2_pulses", n_pulses - p0, 32'd3);

    // 3. Full / backpressure
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_ref(i, 1'b0);
    in_data = 32'd5; cur_exp = 16'd5; cur_clip = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t3_full_in_ready", {31'd0, in_ready}, 32'd0);
      check("t3_full_count", {29'd0, count}, 32'd4);
      step();
    end
    in_data = 32'd6;
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // 4. Simultaneous push/pop at count=2
    out_ready = 1'b0;
    send_ref(32'd100, 1'b0);
    send_ref(32'd101, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check("t4_head_valid", {31'd0, seen}, 32'd1);
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send_ref($urandom(), 1'b1);
    drain();

    // 5. Reset mid-stream
    out_ready = 1'b0;
    send_ref(32'h0000_0011, 1'b0);
    send_ref(32'h7000_0000, 1'b0);
    send_ref(32'hFFFF_FF00, 1'b0);
    reset = 1'b1; in_valid = 1'b1; in_data = 32'h0000_0055;
    step();
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("t5_out_valid", {31'd0, out_valid}, 32'd0);
    check("t5_count", {29'd0, count}, 32'd0);
    check("t5_clip_count", {24'd0, clip_count}, 32'd0);
    step();
    out_ready = 1'b1;
    send_ref(32'h0000_0042, 1'b0);
    @(negedge clk);
    check("t5_no_bypass", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("t5_emerge_valid", {31'd0, out_valid}, 32'd1);
    check("t5_emerge_data", {16'd0, out_data}, 32'h42);
    step();
    drain();

    // 6. Clip counter cap
    p0 = n_pulses;
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) send_ref(32'h0001_0000 + i, 1'b0);
      else            send_ref(32'h8000_0000 + i, 1'b0);
    end
    drain();
    check("t6_clip_cap", {24'd0, clip_count}, 32'd255);
    check("t6_pulses", n_pulses - p0, 32'd300);
    check("end_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
